// File: rtl/latch_dump_sequencer_if.sv
// ----------------------------------------------------------------------------
// latch_dump_sequencer_if
//
// Bundles the two buses the dump sequencer drives:
//   * the selector/data pair to the pipeline-latch debug multiplexer
//   * the valid/ready byte stream to the debug UART transmitter
//
// Signals:
//   mux_sel   [6:0]   selector code to the latch debug mux
//   mux_data  [31:0]  registered word returned by the latch debug mux
//   tx_data   [7:0]   byte to the UART transmitter
//   tx_valid          tx_data is valid
//   tx_ready          UART transmitter accepts the byte
//
// Modports:
//   master  the sequencer side (drives mux_sel, tx_data, tx_valid)
//   slave   the mux + UART side (drives mux_data, tx_ready)
// ----------------------------------------------------------------------------
interface latch_dump_sequencer_if;

    logic [6:0]  mux_sel;
    logic [31:0] mux_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output mux_sel,
        input  mux_data,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  mux_sel,
        output mux_data,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface : latch_dump_sequencer_if

// File: rtl/latch_dump_sequencer.sv
// ----------------------------------------------------------------------------
// latch_dump_sequencer
//
// Walks the pipeline-latch debug mux through its 19 valid selector codes.
// For each code it presents the selector, waits for the mux's registered
// word, and streams that word as 4 bytes to the debug UART transmitter.
//
// Parameters:
//   MUX_LATENCY  cycles from a selector being presented to its data being
//                valid on mux_data (>= 1)
//   LSB_FIRST    0: byte [31:24] goes out first; 1: byte [7:0] goes out first
//
// Ports:
//   clk       clock, all state on the rising edge
//   rst       asynchronous, active-high reset
//   start     single-cycle request to begin a full dump (sampled in IDLE only)
//   dbg       master side of latch_dump_sequencer_if (mux bus + byte stream)
//   busy      dump in progress (SEL, WAIT, SEND)
//   done      one-cycle pulse when the dump completes
//   word_idx  index of the word being dumped (0..18)
//
// Timing with tx_ready held high: SEL 1 + WAIT MUX_LATENCY + SEND 4 cycles
// per word; the first byte is valid MUX_LATENCY+2 cycles after start is
// sampled.
// ----------------------------------------------------------------------------
module latch_dump_sequencer #(
    parameter int MUX_LATENCY = 1,
    parameter bit LSB_FIRST   = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    latch_dump_sequencer_if.master        dbg,
    output logic                          busy,
    output logic                          done,
    output logic [4:0]                    word_idx
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [6:0] IDLE_CODE = 7'h7F;  // unused code, parks the mux
    localparam logic [4:0] LAST_IDX  = 5'd18;  // 19 words: 0..18
    localparam logic [1:0] LAST_BYTE = 2'd3;

    // Wait counter only needs to reach MUX_LATENCY-1.
    localparam int           WAIT_W    = (MUX_LATENCY > 1) ? $clog2(MUX_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MUX_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        WAIT,
        SEND,
        FIN
    } stateType;

    // ------------------------------------------------------------------------
    // Selector code ROM, in dump order.
    // NOTE: the ROM is pure combinational decode, so it holds no storage that
    // would need a reset; only the real state registers below are reset.
    // ------------------------------------------------------------------------
    function automatic logic [6:0] romCode(input logic [4:0] idx);
        case (idx)
            5'd0:    romCode = 7'h00;
            5'd1:    romCode = 7'h01;
            5'd2:    romCode = 7'h10;
            5'd3:    romCode = 7'h11;
            5'd4:    romCode = 7'h12;
            5'd5:    romCode = 7'h13;
            5'd6:    romCode = 7'h14;
            5'd7:    romCode = 7'h15;
            5'd8:    romCode = 7'h20;
            5'd9:    romCode = 7'h21;
            5'd10:   romCode = 7'h23;
            5'd11:   romCode = 7'h24;
            5'd12:   romCode = 7'h25;
            5'd13:   romCode = 7'h30;
            5'd14:   romCode = 7'h31;
            5'd15:   romCode = 7'h32;
            5'd16:   romCode = 7'h33;
            5'd17:   romCode = 7'h40;
            5'd18:   romCode = 7'h41;
            default: romCode = IDLE_CODE;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    stateType          state;
    stateType          nextState;
    logic [6:0]        muxSelReg;
    logic [31:0]       shiftReg;
    logic [1:0]        byteCnt;
    logic [WAIT_W-1:0] waitCnt;
    logic              xfer;
    logic              waitDone;
    logic              wordDone;

    // ------------------------------------------------------------------------
    // State register
    // NOTE: every clocked assignment is non-blocking so all registers update
    // together from pre-edge values, independent of statement order.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    // ------------------------------------------------------------------------
    always_comb begin
        nextState = state;
        xfer      = 1'b0;
        waitDone  = 1'b0;
        wordDone  = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    nextState = SEL;
                end
            end

            SEL: begin
                nextState = WAIT;
            end

            WAIT: begin
                waitDone = (waitCnt == WAIT_LAST);
                if (waitDone) begin
                    nextState = SEND;
                end
            end

            SEND: begin
                // tx_valid is high for the whole of SEND, so ready alone
                // decides whether this edge is a transfer.
                xfer     = dbg.tx_ready;
                wordDone = xfer && (byteCnt == LAST_BYTE);
                if (wordDone) begin
                    nextState = (word_idx == LAST_IDX) ? FIN : SEL;
                end
            end

            FIN: begin
                nextState = IDLE;
            end

            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: selector, word index, wait counter, byte shifter.
    // mux_sel and word_idx change only on the edges that enter SEL or FIN.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            muxSelReg <= IDLE_CODE;
            word_idx  <= 5'd0;
            waitCnt   <= '0;
            byteCnt   <= 2'd0;
            shiftReg  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        word_idx  <= 5'd0;
                        muxSelReg <= romCode(5'd0);
                    end
                end

                SEL: begin
                    waitCnt <= '0;
                end

                WAIT: begin
                    waitCnt <= waitCnt + 1'b1;
                    if (waitDone) begin
                        shiftReg <= dbg.mux_data;
                        byteCnt  <= 2'd0;
                    end
                end

                SEND: begin
                    if (wordDone) begin
                        if (word_idx == LAST_IDX) begin
                            muxSelReg <= IDLE_CODE;
                            word_idx  <= 5'd0;
                        end else begin
                            muxSelReg <= romCode(word_idx + 5'd1);
                            word_idx  <= word_idx + 5'd1;
                        end
                    end else if (xfer) begin
                        // Move the next byte into the output slot so it is
                        // presented back-to-back on the following cycle.
                        byteCnt <= byteCnt + 2'd1;
                        if (LSB_FIRST) begin
                            shiftReg <= {8'h00, shiftReg[31:8]};
                        end else begin
                            shiftReg <= {shiftReg[23:0], 8'h00};
                        end
                    end
                end

                default: begin
                    // FIN: selector and index were already parked on entry.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. All are decoded from registers, so they are glitch-free and
    // stable for the whole cycle; tx_data/tx_valid therefore hold until the
    // transfer edge.
    // ------------------------------------------------------------------------
    assign dbg.mux_sel  = muxSelReg;
    assign dbg.tx_data  = LSB_FIRST ? shiftReg[7:0] : shiftReg[31:24];
    assign dbg.tx_valid = (state == SEND);
    assign busy         = (state == SEL) || (state == WAIT) || (state == SEND);
    assign done         = (state == FIN);

endmodule : latch_dump_sequencer

// File: tb/tb_latch_dump_sequencer.sv
// ----------------------------------------------------------------------------
// tb_latch_dump_sequencer
//
// Three sequencer instances share clk/rst:
//   dutA  MUX_LATENCY=1, LSB_FIRST=0
//   dutB  MUX_LATENCY=1, LSB_FIRST=1
//   dutC  MUX_LATENCY=2, LSB_FIRST=0
// Each has its own mux model returning {25'h0, sel} (or 32'hDEADBEEF for
// code 00 when overrideOn is set) after that instance's latency.
// Expected bytes are queued when a dump is started and popped on each
// valid&ready cycle.
// ----------------------------------------------------------------------------
module tb_latch_dump_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic overrideOn = 1'b0;

    logic [6:0] codes [19] = '{7'h00, 7'h01, 7'h10, 7'h11, 7'h12, 7'h13, 7'h14,
                               7'h15, 7'h20, 7'h21, 7'h23, 7'h24, 7'h25, 7'h30,
                               7'h31, 7'h32, 7'h33, 7'h40, 7'h41};

    typedef struct {
        logic [7:0] data;
        logic [6:0] code;
        logic [4:0] idx;
    } expT;

    expT sb [$];

    // ------------------------------------------------------------------------
    // DUTs and per-instance signal views
    // ------------------------------------------------------------------------
    latch_dump_sequencer_if ifA ();
    latch_dump_sequencer_if ifB ();
    latch_dump_sequencer_if ifC ();

    logic [2:0] startV    = 3'b000;
    logic [2:0] txReadyV  = 3'b000;
    logic [2:0] busyV;
    logic [2:0] doneV;
    logic [2:0] validV;
    logic [7:0] txData  [3];
    logic [6:0] muxSel  [3];
    logic [4:0] wordIdx [3];

    assign ifA.tx_ready = txReadyV[0];
    assign ifB.tx_ready = txReadyV[1];
    assign ifC.tx_ready = txReadyV[2];
    assign validV[0] = ifA.tx_valid;
    assign validV[1] = ifB.tx_valid;
    assign validV[2] = ifC.tx_valid;
    assign txData[0] = ifA.tx_data;
    assign txData[1] = ifB.tx_data;
    assign txData[2] = ifC.tx_data;
    assign muxSel[0] = ifA.mux_sel;
    assign muxSel[1] = ifB.mux_sel;
    assign muxSel[2] = ifC.mux_sel;

    latch_dump_sequencer #(.MUX_LATENCY(1), .LSB_FIRST(1'b0)) dutA (
        .clk(clk), .rst(rst), .start(startV[0]), .dbg(ifA),
        .busy(busyV[0]), .done(doneV[0]), .word_idx(wordIdx[0])
    );
    latch_dump_sequencer #(.MUX_LATENCY(1), .LSB_FIRST(1'b1)) dutB (
        .clk(clk), .rst(rst), .start(startV[1]), .dbg(ifB),
        .busy(busyV[1]), .done(doneV[1]), .word_idx(wordIdx[1])
    );
    latch_dump_sequencer #(.MUX_LATENCY(2), .LSB_FIRST(1'b0)) dutC (
        .clk(clk), .rst(rst), .start(startV[2]), .dbg(ifC),
        .busy(busyV[2]), .done(doneV[2]), .word_idx(wordIdx[2])
    );

    // ------------------------------------------------------------------------
    // Mux models
    // ------------------------------------------------------------------------
    function automatic logic [31:0] muxFn(input logic [6:0] sel);
        if (overrideOn && sel == 7'h00) return 32'hDEADBEEF;
        return {25'h0, sel};
    endfunction

    function automatic bit lsbOf(input int d);
        return (d == 1);
    endfunction

    function automatic int latOf(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    logic [31:0] pipeC = 32'h0;
    initial begin
        ifA.mux_data = 32'h0;
        ifB.mux_data = 32'h0;
        ifC.mux_data = 32'h0;
    end
    always @(posedge clk) begin
        ifA.mux_data <= muxFn(ifA.mux_sel);
        ifB.mux_data <= muxFn(ifB.mux_sel);
        pipeC        <= muxFn(ifC.mux_sel);
        ifC.mux_data <= pipeC;
    end

    // ------------------------------------------------------------------------
    // Full dump on instance d.
    //   readyMode 0: tx_ready always 1; 1: tx_ready high one cycle in three
    //   expDone   expected done cycle (cycle 0 = start sampled), -1 to skip
    //   poke      pulse start during word 5 and during FIN
    // ------------------------------------------------------------------------
    task automatic runDump(input int d, input int readyMode, input int expDone, input bit poke);
        int c, nXfer, nDone, doneAt, after, firstValid, sh;
        bit pokedW5, stalled, ready;
        logic [7:0] prevData;
        logic [6:0] prevSel;
        logic [31:0] w;
        expT e;

        sb.delete();
        for (int wi = 0; wi < 19; wi++) begin
            w = muxFn(codes[wi]);
            for (int b = 0; b < 4; b++) begin
                sh     = lsbOf(d) ? 8 * b : 8 * (3 - b);
                e.data = w[sh +: 8];
                e.code = codes[wi];
                e.idx  = 5'(wi);
                sb.push_back(e);
            end
        end

        nXfer = 0; nDone = 0; doneAt = -1; after = 0; firstValid = -1;
        pokedW5 = 1'b0; stalled = 1'b0; prevData = 8'h0; prevSel = 7'h0;

        startV[d]   = 1'b1;
        txReadyV[d] = 1'b0;
        @(posedge clk); #1;
        c = 1;
        while (c < 2000 && after < 8) begin
            startV[d] = 1'b0;
            ready = (readyMode == 0) ? 1'b1 : (c % 3 == 0);
            txReadyV[d] = ready;

            if (validV[d] && firstValid < 0) firstValid = c;

            if (stalled) begin
                checks++;
                if (validV[d] !== 1'b1 || txData[d] !== prevData || muxSel[d] !== prevSel) begin
                    errors++;
                    $display("FAIL stall_hold dut%0d cycle %0d: valid=%b data=%h sel=%h, required valid=1 data=%h sel=%h",
                             d, c, validV[d], txData[d], muxSel[d], prevData, prevSel);
                end
            end

            if (doneV[d]) begin
                nDone++;
                if (nDone == 1) doneAt = c;
                checks++;
                if (busyV[d] !== 1'b0 || muxSel[d] !== 7'h7F || wordIdx[d] !== 5'd0) begin
                    errors++;
                    $display("FAIL fin_state dut%0d cycle %0d: busy=%b sel=%h idx=%0d, required busy=0 sel=7f idx=0",
                             d, c, busyV[d], muxSel[d], wordIdx[d]);
                end
                if (poke) startV[d] = 1'b1;
            end else if (nDone == 0) begin
                checks++;
                if (busyV[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_high dut%0d cycle %0d: busy=%b, required 1", d, c, busyV[d]);
                end
            end else begin
                after++;
                checks++;
                if (busyV[d] !== 1'b0 || validV[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_after dut%0d cycle %0d: busy=%b valid=%b, required 0 0",
                             d, c, busyV[d], validV[d]);
                end
            end

            if (poke && !pokedW5 && wordIdx[d] == 5'd5) begin
                startV[d] = 1'b1;
                pokedW5   = 1'b1;
            end

            if (validV[d] && ready) begin
                nXfer++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_byte dut%0d cycle %0d: got %h, required no byte", d, c, txData[d]);
                end else begin
                    e = sb.pop_front();
                    if (txData[d] !== e.data || muxSel[d] !== e.code || wordIdx[d] !== e.idx) begin
                        errors++;
                        $display("FAIL byte dut%0d cycle %0d: data=%h sel=%h idx=%0d, required data=%h sel=%h idx=%0d",
                                 d, c, txData[d], muxSel[d], wordIdx[d], e.data, e.code, e.idx);
                    end
                end
            end

            stalled  = validV[d] && !ready;
            prevData = txData[d];
            prevSel  = muxSel[d];
            @(posedge clk); #1;
            c++;
        end
        startV[d]   = 1'b0;
        txReadyV[d] = 1'b0;

        checks++;
        if (after < 8) begin
            errors++;
            $display("FAIL timeout dut%0d: dump did not finish within %0d cycles", d, c);
        end
        checks++;
        if (nDone != 1) begin
            errors++;
            $display("FAIL done_count dut%0d: got %0d pulses, required 1", d, nDone);
        end
        if (expDone >= 0) begin
            checks++;
            if (doneAt != expDone) begin
                errors++;
                $display("FAIL done_cycle dut%0d: got %0d, required %0d", d, doneAt, expDone);
            end
            checks++;
            if (firstValid != 2 + latOf(d)) begin
                errors++;
                $display("FAIL first_valid dut%0d: got %0d, required %0d", d, firstValid, 2 + latOf(d));
            end
        end
        checks++;
        if (nXfer != 76 || sb.size() != 0) begin
            errors++;
            $display("FAIL byte_count dut%0d: got %0d transfers, %0d left, required 76 and 0",
                     d, nXfer, sb.size());
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({muxSel[d], txData[d], validV[d], busyV[d], doneV[d], wordIdx[d]} !==
                {7'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0}) begin
                errors++;
                $display("FAIL reset_state dut%0d: sel=%h data=%h valid=%b busy=%b done=%b idx=%0d, required 7f 00 0 0 0 0",
                         d, muxSel[d], txData[d], validV[d], busyV[d], doneV[d], wordIdx[d]);
            end
        end
    endtask

    task automatic test_full_dump();
        runDump(0, 0, 115, 1'b0);
    endtask

    task automatic test_byte_order();
        overrideOn = 1'b1;
        runDump(0, 0, 115, 1'b0);   // DE AD BE EF first
        runDump(1, 0, 115, 1'b0);   // EF BE AD DE first
        overrideOn = 1'b0;
    endtask

    task automatic test_backpressure();
        runDump(0, 1, -1, 1'b0);
    endtask

    task automatic test_start_while_busy();
        runDump(0, 0, 115, 1'b1);
    endtask

    task automatic test_reset_mid();
        int nXfer;
        int c;
        nXfer = 0;
        startV[0]   = 1'b1;
        txReadyV[0] = 1'b1;
        @(posedge clk); #1;
        startV[0] = 1'b0;
        c = 1;
        // 30 transfers = words 0..6 plus bytes 0,1 of word 7
        while (c < 500 && !(nXfer == 30 && validV[0])) begin
            if (validV[0]) nXfer++;
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if (wordIdx[0] !== 5'd7 || validV[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_point: idx=%0d valid=%b after %0d cycles, required idx=7 valid=1",
                     wordIdx[0], validV[0], c);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (muxSel[0] !== 7'h7F || validV[0] !== 1'b0 || busyV[0] !== 1'b0 ||
            doneV[0] !== 1'b0 || wordIdx[0] !== 5'd0) begin
            errors++;
            $display("FAIL reset_abort: sel=%h valid=%b busy=%b done=%b idx=%0d, required 7f 0 0 0 0",
                     muxSel[0], validV[0], busyV[0], doneV[0], wordIdx[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (doneV[0] !== 1'b0 || busyV[0] !== 1'b0 || validV[0] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle cycle %0d: done=%b busy=%b valid=%b, required 0 0 0",
                         i, doneV[0], busyV[0], validV[0]);
            end
            @(posedge clk); #1;
        end
        txReadyV[0] = 1'b0;
        runDump(0, 0, 115, 1'b0);   // restarts from code 00
    endtask

    task automatic test_latency2();
        runDump(2, 0, 134, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_full_dump();
        test_byte_order();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid();
        test_latency2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_latch_dump_sequencer
